// File: rtl/mem_access_pkg.sv
// Shared types for the MEM stage: memory opcodes, FSM states and common constants.
// Imported by mem_lane and mem_access.
package mem_access_pkg;

    typedef enum logic [3:0] {
        MEM_NOP = 4'd0,
        MEM_LB  = 4'd1,
        MEM_LBU = 4'd2,
        MEM_LH  = 4'd3,
        MEM_LHU = 4'd4,
        MEM_LW  = 4'd5,
        MEM_SB  = 4'd6,
        MEM_SH  = 4'd7,
        MEM_SW  = 4'd8
    } mem_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mem_state_e;

    localparam int          REG_ADDR_W    = 5;
    localparam int          REG_W         = 32;
    localparam int          SEL_W         = 4;
    localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;
    localparam logic        WRITE_DISABLE = 1'b0;

endpackage

// File: rtl/mem_lane.sv
// Combinational byte-lane logic for the MEM stage: big-endian lane select, store
// replication, load extraction with sign/zero extension and alignment checking.
module mem_lane
    import mem_access_pkg::*;
(
    input  mem_op_e            memop,
    input  logic [1:0]         addr,
    input  logic [REG_W-1:0]   sdata,
    input  logic [REG_W-1:0]   rdata,
    output logic [SEL_W-1:0]   sel,
    output logic [REG_W-1:0]   wdata,
    output logic [REG_W-1:0]   load_data,
    output logic               is_load,
    output logic               is_store,
    output logic               misaligned
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    // Big-endian: byte offset 0 is the most significant lane of the bus word.
    always_comb begin
        rbyte = rdata[31:24];
        case (addr)
            2'd0: rbyte = rdata[31:24];
            2'd1: rbyte = rdata[23:16];
            2'd2: rbyte = rdata[15:8];
            2'd3: rbyte = rdata[7:0];
            default: rbyte = rdata[31:24];
        endcase
        rhalf = addr[1] ? rdata[15:0] : rdata[31:16];
    end

    always_comb begin
        sel        = '0;
        wdata      = ZERO_WORD;
        load_data  = ZERO_WORD;
        is_load    = 1'b0;
        is_store   = 1'b0;
        misaligned = 1'b0;
        case (memop)
            MEM_LB: begin
                is_load   = 1'b1;
                sel       = 4'b1000 >> addr;
                load_data = {{24{rbyte[7]}}, rbyte};
            end
            MEM_LBU: begin
                is_load   = 1'b1;
                sel       = 4'b1000 >> addr;
                load_data = {24'h00_0000, rbyte};
            end
            MEM_LH: begin
                is_load    = 1'b1;
                misaligned = addr[0];
                sel        = addr[1] ? 4'b0011 : 4'b1100;
                load_data  = {{16{rhalf[15]}}, rhalf};
            end
            MEM_LHU: begin
                is_load    = 1'b1;
                misaligned = addr[0];
                sel        = addr[1] ? 4'b0011 : 4'b1100;
                load_data  = {16'h0000, rhalf};
            end
            MEM_LW: begin
                is_load    = 1'b1;
                misaligned = (addr != 2'b00);
                sel        = 4'b1111;
                load_data  = rdata;
            end
            MEM_SB: begin
                is_store = 1'b1;
                sel      = 4'b1000 >> addr;
                wdata    = {4{sdata[7:0]}};
            end
            MEM_SH: begin
                is_store   = 1'b1;
                misaligned = addr[0];
                sel        = addr[1] ? 4'b0011 : 4'b1100;
                wdata      = {2{sdata[15:0]}};
            end
            MEM_SW: begin
                is_store   = 1'b1;
                misaligned = (addr != 2'b00);
                sel        = 4'b1111;
                wdata      = sdata;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// MEM stage of the 5-stage MIPS pipeline: passes ALU results through and runs a
// req/ack data-bus transaction for loads and stores, stalling upstream until done.
module mem_access
    import mem_access_pkg::*;
#(
    parameter logic [15:0] TIMEOUT = 16'd255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] ex_wd,
    input  logic                  ex_wreg,
    input  logic [REG_W-1:0]      ex_wdata,
    input  logic [3:0]            ex_memop,
    input  logic [REG_W-1:0]      ex_maddr,
    input  logic [REG_W-1:0]      ex_sdata,
    output logic [REG_ADDR_W-1:0] mem_wd,
    output logic                  mem_wreg,
    output logic [REG_W-1:0]      mem_wdata,
    output logic                  stall_req,
    output logic                  addr_err,
    output logic                  bus_err,
    output logic                  dbus_req,
    output logic                  dbus_we,
    output logic [REG_W-1:0]      dbus_addr,
    output logic [SEL_W-1:0]      dbus_sel,
    output logic [REG_W-1:0]      dbus_wdata,
    input  logic [REG_W-1:0]      dbus_rdata,
    input  logic                  dbus_ack
);

    localparam logic [15:0] LAST_COUNT = TIMEOUT - 16'd1;

    mem_state_e        state;
    mem_state_e        state_next;
    logic [15:0]       count;
    mem_op_e           memop;
    logic [SEL_W-1:0]  lane_sel;
    logic [REG_W-1:0]  lane_wdata;
    logic [REG_W-1:0]  lane_load;
    logic              is_load;
    logic              is_store;
    logic              misaligned;
    logic              start;
    logic              finish;

    assign memop = mem_op_e'(ex_memop);

    mem_lane u_lane (
        .memop      (memop),
        .addr       (ex_maddr[1:0]),
        .sdata      (ex_sdata),
        .rdata      (dbus_rdata),
        .sel        (lane_sel),
        .wdata      (lane_wdata),
        .load_data  (lane_load),
        .is_load    (is_load),
        .is_store   (is_store),
        .misaligned (misaligned)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Upstream holds ex_* stable while stalled, so the ack cycle can still extract from them.
    always_comb begin
        state_next = state;
        mem_wd     = ex_wd;
        mem_wreg   = ex_wreg;
        mem_wdata  = ex_wdata;
        stall_req  = 1'b0;
        addr_err   = 1'b0;
        bus_err    = 1'b0;
        start      = 1'b0;
        finish     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (is_load || is_store) begin
                    mem_wreg = WRITE_DISABLE;
                    if (misaligned) begin
                        addr_err = 1'b1;
                    end else begin
                        stall_req  = 1'b1;
                        start      = 1'b1;
                        state_next = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                mem_wreg = WRITE_DISABLE;
                if (dbus_ack) begin
                    finish     = 1'b1;
                    state_next = ST_IDLE;
                    if (is_load) begin
                        mem_wreg  = ex_wreg;
                        mem_wdata = lane_load;
                    end
                end else if (count == LAST_COUNT) begin
                    bus_err    = 1'b1;
                    finish     = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    stall_req = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dbus_req   <= 1'b0;
            dbus_we    <= 1'b0;
            dbus_addr  <= ZERO_WORD;
            dbus_sel   <= '0;
            dbus_wdata <= ZERO_WORD;
            count      <= 16'd0;
        end else if (start) begin
            dbus_req   <= 1'b1;
            dbus_we    <= is_store;
            dbus_addr  <= {ex_maddr[31:2], 2'b00};
            dbus_sel   <= lane_sel;
            dbus_wdata <= lane_wdata;
            count      <= 16'd0;
        end else if (finish) begin
            dbus_req <= 1'b0;
        end else if (state == ST_BUSY) begin
            count <= count + 16'd1;
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: expected writeback/bus results are queued when an
// operation is driven and popped when the stage releases the stall.
module tb_mem_access;
    import mem_access_pkg::*;

    logic        clk;
    logic        rst;
    logic [4:0]  ex_wd;
    logic        ex_wreg;
    logic [31:0] ex_wdata;
    logic [3:0]  ex_memop;
    logic [31:0] ex_maddr;
    logic [31:0] ex_sdata;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic        stall_req;
    logic        addr_err;
    logic        bus_err;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [3:0]  dbus_sel;
    logic [31:0] dbus_wdata;
    logic [31:0] dbus_rdata;
    logic        dbus_ack;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic        aerr;
        logic        berr;
        logic        bus;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] bwdata;
        logic [31:0] baddr;
        int          stalls;
    } exp_t;

    exp_t sb[$];

    mem_access #(.TIMEOUT(16'd4)) dut (
        .clk        (clk),
        .rst        (rst),
        .ex_wd      (ex_wd),
        .ex_wreg    (ex_wreg),
        .ex_wdata   (ex_wdata),
        .ex_memop   (ex_memop),
        .ex_maddr   (ex_maddr),
        .ex_sdata   (ex_sdata),
        .mem_wd     (mem_wd),
        .mem_wreg   (mem_wreg),
        .mem_wdata  (mem_wdata),
        .stall_req  (stall_req),
        .addr_err   (addr_err),
        .bus_err    (bus_err),
        .dbus_req   (dbus_req),
        .dbus_we    (dbus_we),
        .dbus_addr  (dbus_addr),
        .dbus_sel   (dbus_sel),
        .dbus_wdata (dbus_wdata),
        .dbus_rdata (dbus_rdata),
        .dbus_ack   (dbus_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // Reference model: derives lane data by shifting the bus word rather than case-selecting.
    function automatic exp_t model(input mem_op_e op, input logic [31:0] addr, input logic [31:0] sdata,
                                   input logic [31:0] rdata, input logic [4:0] wd, input logic wreg,
                                   input logic [31:0] wdata, input int ack_wait);
        exp_t        e;
        logic [1:0]  off;
        logic [31:0] sh;
        int          size;
        bit          sgn;
        bit          st;
        off = addr[1:0];
        sh  = rdata << (8 * off);
        e.wd = wd; e.wreg = wreg; e.wdata = wdata;
        e.aerr = 1'b0; e.berr = 1'b0; e.bus = 1'b0; e.we = 1'b0;
        e.sel = 4'h0; e.bwdata = 32'h0; e.baddr = {addr[31:2], 2'b00}; e.stalls = 0;
        size = 0; sgn = 1'b0; st = 1'b0;
        case (op)
            MEM_LB:  begin size = 1; sgn = 1'b1; end
            MEM_LBU: size = 1;
            MEM_LH:  begin size = 2; sgn = 1'b1; end
            MEM_LHU: size = 2;
            MEM_LW:  size = 4;
            MEM_SB:  begin size = 1; st = 1'b1; end
            MEM_SH:  begin size = 2; st = 1'b1; end
            MEM_SW:  begin size = 4; st = 1'b1; end
            default: size = 0;
        endcase
        if (size == 0) return e;
        if ((size == 2 && off[0]) || (size == 4 && off != 2'b00)) begin
            e.aerr = 1'b1; e.wreg = 1'b0;
            return e;
        end
        e.bus = 1'b1;
        e.we  = st;
        if (size == 1) begin
            e.sel = 4'b1000 >> off; e.bwdata = {4{sdata[7:0]}};
        end else if (size == 2) begin
            e.sel = off[1] ? 4'b0011 : 4'b1100; e.bwdata = {2{sdata[15:0]}};
        end else begin
            e.sel = 4'b1111; e.bwdata = sdata;
        end
        if (ack_wait < 0 || ack_wait > 3) begin
            e.berr = 1'b1; e.wreg = 1'b0; e.stalls = 4;
            return e;
        end
        e.stalls = 1 + ack_wait;
        if (st) e.wreg = 1'b0;
        else if (size == 1) e.wdata = sgn ? {{24{sh[31]}}, sh[31:24]} : {24'h0, sh[31:24]};
        else if (size == 2) e.wdata = sgn ? {{16{sh[31]}}, sh[31:16]} : {16'h0, sh[31:16]};
        else e.wdata = rdata;
        return e;
    endfunction

    // Entered and left at posedge+1; ack is raised ack_wait BUSY cycles after the first one.
    task automatic applyStimulus(input string tag, input mem_op_e op, input logic [31:0] addr,
                                 input logic [31:0] sdata, input logic [31:0] rdata, input logic [4:0] wd,
                                 input logic wreg, input logic [31:0] wdata, input int ack_wait);
        exp_t e;
        int   stalls = 0;
        bit   done = 1'b0;
        bit   saw_req = 1'b0;
        sb.push_back(model(op, addr, sdata, rdata, wd, wreg, wdata, ack_wait));
        ex_wd = wd; ex_wreg = wreg; ex_wdata = wdata; ex_memop = op;
        ex_maddr = addr; ex_sdata = sdata; dbus_rdata = rdata; dbus_ack = 1'b0;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            dbus_ack = (ack_wait >= 0 && cyc == ack_wait + 1);
            #3;
            if (dbus_req && !saw_req) begin
                saw_req = 1'b1;
                checkOutput({tag, ".sel"}, 32'(dbus_sel), 32'(sb[0].sel));
                checkOutput({tag, ".we"}, 32'(dbus_we), 32'(sb[0].we));
                checkOutput({tag, ".baddr"}, dbus_addr, sb[0].baddr);
                if (sb[0].we) checkOutput({tag, ".bwdata"}, dbus_wdata, sb[0].bwdata);
            end
            if (stall_req) begin
                stalls++;
                checkOutput({tag, ".stallwreg"}, 32'(mem_wreg), 32'd0);
                @(posedge clk); #1;
            end else begin
                done = 1'b1;
            end
        end
        e = sb.pop_front();
        checkOutput({tag, ".done"}, 32'(done), 32'd1);
        checkOutput({tag, ".wd"}, 32'(mem_wd), 32'(e.wd));
        checkOutput({tag, ".wreg"}, 32'(mem_wreg), 32'(e.wreg));
        if (e.wreg) checkOutput({tag, ".wdata"}, mem_wdata, e.wdata);
        checkOutput({tag, ".aerr"}, 32'(addr_err), 32'(e.aerr));
        checkOutput({tag, ".berr"}, 32'(bus_err), 32'(e.berr));
        checkOutput({tag, ".stalls"}, 32'(stalls), 32'(e.stalls));
        checkOutput({tag, ".sawreq"}, 32'(saw_req), 32'(e.bus));
        @(posedge clk); #1;
        dbus_ack = 1'b0;
        ex_memop = MEM_NOP;
        #3;
        checkOutput({tag, ".reqdrop"}, 32'(dbus_req), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        mem_op_e ops[8] = '{MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW, MEM_SB, MEM_SH, MEM_SW};
        rst = 1'b1; ex_wd = 5'd0; ex_wreg = 1'b0; ex_wdata = 32'h0; ex_memop = MEM_NOP;
        ex_maddr = 32'h0; ex_sdata = 32'h0; dbus_rdata = 32'h0; dbus_ack = 1'b0;
        repeat (2) @(posedge clk);
        #4;
        checkOutput("rst.req", 32'(dbus_req), 32'd0);
        checkOutput("rst.we", 32'(dbus_we), 32'd0);
        checkOutput("rst.addr", dbus_addr, 32'h0);
        checkOutput("rst.sel", 32'(dbus_sel), 32'd0);
        checkOutput("rst.wdata", dbus_wdata, 32'h0);
        checkOutput("rst.stall", 32'(stall_req), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        applyStimulus("add", MEM_NOP, 32'h0, 32'h0, 32'h0, 5'd5, 1'b1, 32'h0000_1234, 0);
        applyStimulus("lb", MEM_LB, 32'h0000_1001, 32'h0, 32'h0080_0000, 5'd3, 1'b1, 32'hDEAD, 0);
        applyStimulus("sh", MEM_SH, 32'h0000_2002, 32'hAAAA_BEEF, 32'h0, 5'd4, 1'b0, 32'h0, 3);
        applyStimulus("lw_mis", MEM_LW, 32'h0000_3001, 32'h0, 32'h1111_2222, 5'd7, 1'b1, 32'h55, 0);
        applyStimulus("lw_to", MEM_LW, 32'h0000_3000, 32'h0, 32'h1111_2222, 5'd8, 1'b1, 32'h66, -1);
        applyStimulus("lw_ack4", MEM_LW, 32'h0000_3004, 32'h0, 32'hCAFE_F00D, 5'd9, 1'b1, 32'h77, 3);
        applyStimulus("lh_mis", MEM_LH, 32'h0000_5003, 32'h0, 32'h0, 5'd2, 1'b1, 32'h1, 0);
        applyStimulus("sw_mis", MEM_SW, 32'h0000_5002, 32'h1234_5678, 32'h0, 5'd0, 1'b0, 32'h0, 0);
        applyStimulus("sb", MEM_SB, 32'h0000_6003, 32'h1234_56A5, 32'h0, 5'd0, 1'b0, 32'h0, 1);
        applyStimulus("lhs", MEM_LH, 32'h0000_6000, 32'h0, 32'h9ABC_1234, 5'd11, 1'b1, 32'h0, 2);

        for (int i = 0; i < 16; i++) begin
            applyStimulus("rnd", ops[$urandom_range(7, 0)], $urandom, $urandom, $urandom,
                          5'($urandom_range(31, 0)), 1'b1, $urandom, int'($urandom_range(2, 0)));
        end

        // Reset mid-transaction, then a late ack that must be ignored.
        ex_wd = 5'd12; ex_wreg = 1'b1; ex_wdata = 32'h0000_0ABC; ex_memop = MEM_LHU;
        ex_maddr = 32'h0000_4002; dbus_rdata = 32'hFFFF_FFFF; dbus_ack = 1'b0;
        #3;
        checkOutput("rstmid.stall", 32'(stall_req), 32'd1);
        @(posedge clk); #4;
        checkOutput("rstmid.busyreq", 32'(dbus_req), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        ex_memop = MEM_NOP;
        dbus_ack = 1'b1;
        #3;
        checkOutput("rstmid.req", 32'(dbus_req), 32'd0);
        checkOutput("rstmid.nostall", 32'(stall_req), 32'd0);
        checkOutput("rstmid.wreg", 32'(mem_wreg), 32'd1);
        checkOutput("rstmid.wdata", mem_wdata, 32'h0000_0ABC);
        @(posedge clk); #1;
        dbus_ack = 1'b0;
        #3;
        checkOutput("rstmid.lateack", 32'(dbus_req), 32'd0);
        @(posedge clk); #1;
        applyStimulus("lhu", MEM_LHU, 32'h0000_4002, 32'h0, 32'h0000_8001, 5'd13, 1'b1, 32'h0, 0);

        checkOutput("sb.empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
